// File: rtl/an_encoder_serial16.sv
// an_encoder_serial16: serial shift-and-add AN-code encoder, W = A * N.
// A 16-bit data word is accepted in IDLE, multiplied by the constant A over 16
// MUL cycles (one multiplier bit per cycle), and the 29-bit codeword is held in
// DONE until the downstream stage takes it. Throughput is one word per 18
// cycles without back-pressure.
//
// Optional feature: define ERR_INJECT_EN to add single arithmetic-weight error
// injection (W +/- 2^i mod 2^29), captured with the data word.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream word present
//   in_ready   block idle and able to accept a word
//   in_data    data word N (16 bits, unsigned)
//   out_valid  codeword present
//   out_ready  downstream accepts the codeword
//   out_code   codeword W (29 bits), zero whenever out_valid is low
//   inj_en     (ERR_INJECT_EN only) inject an error into this word
//   inj_neg    (ERR_INJECT_EN only) 1: subtract 2^i, 0: add 2^i
//   inj_pos    (ERR_INJECT_EN only) error bit position i; 29..31 mean no error
module an_encoder_serial16 #(
  parameter int unsigned A = 4547
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [28:0] out_code
`ifdef ERR_INJECT_EN
  ,
  input  logic        inj_en,
  input  logic        inj_neg,
  input  logic [4:0]  inj_pos
`endif
);

  localparam logic [28:0] AWord = 29'(A);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e      state;
  logic [28:0] acc;
  logic [15:0] sr;
  logic [3:0]  cnt;

  logic [28:0] addend;
  logic [28:0] acc_sum;
  logic [28:0] final_code;

`ifdef ERR_INJECT_EN
  logic        inj_en_q;
  logic        inj_neg_q;
  logic [4:0]  inj_pos_q;
  logic [28:0] err;
`endif

  always_comb begin
    addend  = sr[0] ? (AWord << cnt) : 29'd0;
    acc_sum = acc + addend;
`ifdef ERR_INJECT_EN
    // Positions beyond the codeword width inject nothing.
    err = (inj_en_q && (inj_pos_q <= 5'd28)) ? (29'd1 << inj_pos_q) : 29'd0;
    // Wraps modulo 2^29, e.g. 0 - 1 gives all ones.
    final_code = inj_neg_q ? (acc_sum - err) : (acc_sum + err);
`else
    final_code = acc_sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      acc       <= '0;
      sr        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_code  <= '0;
`ifdef ERR_INJECT_EN
      inj_en_q  <= 1'b0;
      inj_neg_q <= 1'b0;
      inj_pos_q <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            sr       <= in_data;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= StMul;
`ifdef ERR_INJECT_EN
            inj_en_q  <= inj_en;
            inj_neg_q <= inj_neg;
            inj_pos_q <= inj_pos;
`endif
          end
        end
        StMul: begin
          acc <= acc_sum;
          sr  <= sr >> 1;
          cnt <= cnt + 4'd1;
          // Last multiplier bit: publish the finished (and possibly corrupted)
          // product in the same edge so out_valid rises 16 edges after accept.
          if (cnt == 4'd15) begin
            state     <= StDone;
            out_valid <= 1'b1;
            out_code  <= final_code;
          end
        end
        StDone: begin
          if (out_ready) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            out_code  <= '0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_code  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_an_encoder_serial16.sv
module tb_an_encoder_serial16;

  localparam int unsigned A = 4547;
  localparam longint      Mod = longint'(1) << 29;
`ifdef ERR_INJECT_EN
  localparam bit InjOn = 1'b1;
`else
  localparam bit InjOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [28:0] out_code;
  logic        inj_en;
  logic        inj_neg;
  logic [4:0]  inj_pos;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  an_encoder_serial16 #(.A(A)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code)
`ifdef ERR_INJECT_EN
    ,
    .inj_en    (inj_en),
    .inj_neg   (inj_neg),
    .inj_pos   (inj_pos)
`endif
  );

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference codeword straight from the arithmetic definition.
  function automatic longint model(input longint n, input bit en, input bit neg,
                                   input int pos);
    longint w;
    w = longint'(A) * n;
    if (InjOn && en && pos <= 28) w = neg ? w - (longint'(1) << pos) : w + (longint'(1) << pos);
    return ((w % Mod) + Mod) % Mod;
  endfunction

  // Behavioural SEC decoder: a valid codeword is a multiple of A with a 16-bit
  // quotient; otherwise try every single +/-2^i correction.
  function automatic longint sec_decode(input longint w);
    longint c;
    if (w % A == 0 && w / A <= 65535) return w / A;
    for (int i = 0; i <= 28; i++) begin
      for (int s = 0; s < 2; s++) begin
        c = s ? w + (longint'(1) << i) : w - (longint'(1) << i);
        c = ((c % Mod) + Mod) % Mod;
        if (c % A == 0 && c / A <= 65535) return c / A;
      end
    end
    return -1;
  endfunction

  task automatic run_word(input logic [15:0] n, input bit en, input bit neg,
                          input logic [4:0] pos, input int stall,
                          output logic [28:0] code);
    int lat;
    int busy_bad;
    int stall_bad;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = n;
    inj_en   = en;
    inj_neg  = neg;
    inj_pos  = pos;
    @(posedge clk); #1;
    lat = 0;
    busy_bad = 0;
    while (!out_valid && lat < 40) begin
      // Inputs outside their handshake state must be ignored.
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      inj_en    = 1'($urandom_range(0, 1));
      inj_pos   = 5'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready || out_code != 0) busy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 16);
    check("busy_outputs", busy_bad, 0);
    code = out_code;
    out_ready = 1'b0;
    stall_bad = 0;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!out_valid || out_code != code || in_ready) stall_bad++;
    end
    if (stall > 0) check("stall_hold", stall_bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("back_to_idle", {in_ready, out_valid}, 2'b10);
    check("code_cleared", out_code, 0);
  endtask

  initial begin
    logic [28:0] code;
    logic [15:0] n;
    bit          en;
    bit          neg;
    logic [4:0]  pos;
    int          bad;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    inj_en = 1'b0; inj_neg = 1'b0; inj_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_code", out_code, 0);
    rst = 1'b0;

    run_word(16'd0, 0, 0, 0, 0, code);
    check("n0", code, 0);
    run_word(16'd1, 0, 0, 0, 0, code);
    check("n1", code, 4547);
    run_word(16'd65535, 0, 0, 0, 1, code);
    check("n65535", code, 297987645);
    run_word(16'd12345, 0, 0, 0, 0, code);
    check("n12345", code, 56132715);
    run_word(16'd100, 0, 0, 0, 50, code);
    check("n100_stall", code, 454700);

    // Reset landing on the 8th MUL edge drops the word.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'd777;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_state", {in_ready, out_valid}, 2'b10);
    check("midrst_code", out_code, 0);
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) bad++;
    end
    check("midrst_no_emit", bad, 0);
    run_word(16'd2, 0, 0, 0, 0, code);
    check("after_rst_n2", code, 9094);

`ifdef ERR_INJECT_EN
    run_word(16'd100, 1, 0, 5'd5, 0, code);
    check("inj_plus5", code, 454732);
    run_word(16'd0, 1, 1, 5'd0, 0, code);
    check("inj_minus0", code, 536870911);
    run_word(16'd100, 1, 0, 5'd30, 0, code);
    check("inj_pos30", code, 454700);
`endif

    for (int k = 0; k < 1000; k++) begin
      n   = 16'($urandom);
      en  = (k % 2) == 1;
      neg = 1'($urandom_range(0, 1));
      pos = 5'($urandom_range(0, 28));
      run_word(n, en, neg, pos, $urandom_range(0, 2), code);
      check("rand_code", code, model(n, en, neg, pos));
      check("rand_decode", sec_decode(longint'(code)), n);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
